puf_cr_engine: RTL
==================

Name: puf_cr_engine

Overview:
- Parametrised challenge/response sequencer sitting between the UART receiver and transmitter in the PUF top level.
- Accepts a binary challenge and converts it to Gray code. Drives the PUF core, waits a programmable settle time, and repeats the evaluation NVOTE times.
- Forms a bitwise majority-voted response, or substitutes the fixed check pattern. Hands the result to the UART TX with a start/done handshake.
- Replaces the fixed 4-stage delay enable and the purely combinational check mux.

Parameters:
- WIDTH, 16, challenge/response width in bits.
- SETTLE, 4, PUF settle cycles between trigger and sample (>=1).
- NVOTE, 3, evaluations per challenge; odd, >=1.
- CHECK_PATTERN, 16'h1234 (zero-extended or truncated to WIDTH), loopback word sent in check mode.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- chal_valid  in  1  challenge available (UART RX done pulse or level)
- chal_bin  in  WIDTH  binary challenge from RX
- chal_ready  out  1  engine idle, can accept a challenge
- check  in  1  sampled at accept; 1 = send CHECK_PATTERN, skip PUF
- puf_chal  out  WIDTH  registered Gray-coded challenge to PUF
- puf_trig  out  1  one-cycle evaluation strobe to PUF
- puf_resp  in  WIDTH  PUF response, sampled after settle
- tx_start  out  1  one-cycle start strobe to UART TX
- tx_data  out  WIDTH  word to transmit, held stable from tx_start until tx_done
- tx_done  in  1  UART TX completion pulse
- busy  out  1  ~chal_ready

Behaviour:
- Reset (async, any state): state=IDLE; chal_ready=1; puf_chal=0, puf_trig=0, tx_start=0, tx_data=0; vote counters, settle and eval counters cleared.
- Accept occurs on a rising edge T with chal_valid & chal_ready. At that edge:
  - puf_chal <= chal_bin ^ (chal_bin >> 1).
  - mode <= check.
  - Vote counters cleared.
- chal_valid while busy is ignored; nothing is queued.
- FSM states: IDLE, ARM, SETTLE, SAMPLE, SEND.
- IDLE:
  - On accept with check=0, go to ARM.
  - On accept with check=1, go to SEND, loading tx_data <= CHECK_PATTERN.
  - In check mode tx_start is asserted in cycle T+1. puf_trig never pulses and puf_chal is still updated.
- ARM: puf_trig=1 for exactly this cycle; go to SETTLE with the settle counter set to SETTLE.
- SETTLE: stay SETTLE cycles, puf_trig=0, then go to SAMPLE.
- SAMPLE (one cycle):
  - For each bit i, cnt[i] += puf_resp[i]. Counter width is clog2(NVOTE+1).
  - eval_cnt increments.
  - If eval_cnt < NVOTE, return to ARM. This guarantees at least SETTLE+1 low cycles between puf_trig pulses.
  - Otherwise tx_data[i] <= (cnt[i] + puf_resp[i] > NVOTE/2) and go to SEND.
- Normal-mode latency: tx_start is asserted in cycle T+1+NVOTE*(SETTLE+2). Each evaluation costs SETTLE+2 cycles.
- SEND:
  - tx_start=1 on the first SEND cycle only; tx_data held.
  - Wait for tx_done; the cycle after tx_done, go to IDLE with chal_ready=1.
  - A tx_done in the same cycle as tx_start is honoured.
- chal_ready=1 only in IDLE. A new challenge can be accepted on the cycle chal_ready returns.
- NVOTE=1: response equals a single sample, no voting skew.
- Ties are impossible because NVOTE is odd; even NVOTE is a configuration error, flagged by a simulation assertion.
- puf_chal holds its value until the next accept and is not cleared on completion.
- Reset mid-operation aborts immediately, with no tx_start afterwards. A tx_done arriving after reset in IDLE is ignored.

Test Plan:
- Gray conversion: WIDTH=16, check=0, chal_bin=16'h0005 -> puf_chal=16'h0007; chal_bin=16'hFFFF -> 16'h8000.
- Check mode: check=1, chal_bin=16'hABCD accepted at T -> tx_start at T+1, tx_data=16'h1234, zero puf_trig pulses; tx_done 20 cycles later -> chal_ready=1 next cycle.
- Voting: NVOTE=3, SETTLE=4, puf_resp sequence 16'h00FF, 16'h0F0F, 16'h00F0 -> exactly 3 puf_trig pulses 6 cycles apart; tx_data=16'h00FF; tx_start at T+19.
- NVOTE=1, puf_resp=16'hBEEF -> tx_data=16'hBEEF; tx_start at T+7.
- Busy drop: assert chal_valid with 16'h1111 during SETTLE -> ignored, puf_chal unchanged, single transaction completes.
- Reset mid-SETTLE: rst pulse -> all outputs 0, chal_ready=1, no tx_start; next challenge runs the full NVOTE sequence with counters starting from 0.

Source files
------------

// File: rtl/puf_cr_engine.sv
// puf_cr_engine: PUF challenge/response sequencer.
// Gray-codes a challenge, majority-votes NVOTE samples, hands word to TX.
module puf_cr_engine #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned SETTLE        = 4,
  parameter int unsigned NVOTE         = 3,
  parameter logic [63:0] CHECK_PATTERN = 64'h1234
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chal_valid,
  input  logic [WIDTH-1:0] chal_bin,
  output logic             chal_ready,
  input  logic             check,
  output logic [WIDTH-1:0] puf_chal,
  output logic             puf_trig,
  input  logic [WIDTH-1:0] puf_resp,
  output logic             tx_start,
  output logic [WIDTH-1:0] tx_data,
  input  logic             tx_done,
  output logic             busy
);

  localparam int unsigned CW = $clog2(NVOTE + 1);
  localparam int unsigned SW = $clog2(SETTLE + 1);
  localparam logic [WIDTH-1:0] CHK = WIDTH'(CHECK_PATTERN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_SETTLE,
    S_SAMPLE,
    S_SEND
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [SW-1:0]            settle_q;
  logic [CW-1:0]            eval_q;
  logic [WIDTH-1:0][CW-1:0] cnt_q;
  logic [WIDTH-1:0]         vote;
  logic                     sent_q;
  logic                     accept;
  logic                     last;

  // A tie-free majority needs an odd number of votes.
  if ((NVOTE % 2) == 0) begin : g_even_nvote
    $error("puf_cr_engine: NVOTE must be odd");
  end

  assign chal_ready = (state_q == S_IDLE);
  assign busy       = ~chal_ready;
  assign accept     = chal_valid & chal_ready;
  assign puf_trig   = (state_q == S_ARM);
  assign tx_start   = (state_q == S_SEND) & ~sent_q;
  assign last       = (32'(eval_q) + 32'd1) >= NVOTE;

  // Majority including the sample currently on puf_resp.
  always_comb begin
    vote = '0;
    for (int i = 0; i < WIDTH; i++) begin
      vote[i] = (32'(cnt_q[i]) + 32'(puf_resp[i])) > (NVOTE / 2);
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = check ? S_SEND : S_ARM;
      S_ARM:    state_d = S_SETTLE;
      S_SETTLE: if (settle_q <= SW'(1)) state_d = S_SAMPLE;
      S_SAMPLE: state_d = last ? S_SEND : S_ARM;
      S_SEND:   if (tx_done) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Challenge, settle timer, vote tallies and TX word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_q <= '0;
      eval_q   <= '0;
      cnt_q    <= '0;
      sent_q   <= 1'b0;
      puf_chal <= '0;
      tx_data  <= '0;
    end else begin
      sent_q <= (state_q == S_SEND);
      if (accept) begin
        puf_chal <= chal_bin ^ (chal_bin >> 1);
        eval_q   <= '0;
        cnt_q    <= '0;
        if (check) tx_data <= CHK;
      end
      if (state_q == S_ARM) settle_q <= SW'(SETTLE);
      if (state_q == S_SETTLE) settle_q <= settle_q - SW'(1);
      if (state_q == S_SAMPLE) begin
        eval_q <= eval_q + CW'(1);
        for (int i = 0; i < WIDTH; i++) begin
          cnt_q[i] <= cnt_q[i] + CW'(puf_resp[i]);
        end
        if (last) tx_data <= vote;
      end
    end
  end

endmodule
